// File: rtl/stream_demux_1to2.sv
// 1-to-2 packet demultiplexer: one registered output slot per channel, with the route
// locked from the first beat of a packet until its last beat.
module stream_demux_1to2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic [7:0]       pkt_cnt0,
  output logic [7:0]       pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_dest;
  logic             w_ready;
  logic             w_acc;
  logic             w_load0;
  logic             w_load1;

  logic             r_vld0_p1;
  logic [WIDTH-1:0] r_data0_p1;
  logic             r_last0_p1;
  logic             r_vld1_p1;
  logic [WIDTH-1:0] r_data1_p1;
  logic             r_last1_p1;
  logic [7:0]       r_cnt0;
  logic [7:0]       r_cnt1;

  // Destination comes from sel only between packets; a mid-packet route is locked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ROUTE0:  w_dest = 1'b0;
      ROUTE1:  w_dest = 1'b1;
      default: w_dest = sel;
    endcase
    // Only the destination slot gates acceptance; the other channel drains on its own.
    w_ready = rst_n & (w_dest ? (~r_vld1_p1 | out1_ready)
                              : (~r_vld0_p1 | out0_ready));
    w_acc   = s_valid & w_ready;
    if (w_acc) begin
      if (s_last) w_state_nxt = IDLE;
      else        w_state_nxt = w_dest ? ROUTE1 : ROUTE0;
    end
    w_load0 = w_acc & ~w_dest;
    w_load1 = w_acc &  w_dest;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stage p1: per-channel output slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld0_p1  <= 1'b0;
      r_data0_p1 <= '0;
      r_last0_p1 <= 1'b0;
    end else if (w_load0) begin
      r_vld0_p1  <= 1'b1;
      r_data0_p1 <= s_data;
      r_last0_p1 <= s_last;
    end else if (out0_ready) begin
      r_vld0_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld1_p1  <= 1'b0;
      r_data1_p1 <= '0;
      r_last1_p1 <= 1'b0;
    end else if (w_load1) begin
      r_vld1_p1  <= 1'b1;
      r_data1_p1 <= s_data;
      r_last1_p1 <= s_last;
    end else if (out1_ready) begin
      r_vld1_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_load0 && s_last) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_load1 && s_last) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign s_ready    = w_ready;
  assign out0_valid = r_vld0_p1;
  assign out0_data  = r_data0_p1;
  assign out0_last  = r_last0_p1;
  assign out1_valid = r_vld1_p1;
  assign out1_data  = r_data1_p1;
  assign out1_last  = r_last1_p1;
  assign pkt_cnt0   = r_cnt0;
  assign pkt_cnt1   = r_cnt1;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: slot/lock model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_stream_demux_1to2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       out0_valid, out0_ready, out0_last;
  logic       out1_valid, out1_ready, out1_last;
  logic [7:0] out0_data, out1_data;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  int checks = 0;
  int errors = 0;

  stream_demux_1to2 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_last(out0_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a one-entry slot; an open packet pins the destination.
  logic       mv [2];
  logic [7:0] md [2];
  logic       ml [2];
  logic [7:0] mc [2];
  int         m_lock = -1;
  bit         m_on = 0;
  int         m_d;
  bit         m_acc;

  function automatic logic rdy_in(input int ch);
    return (ch == 0) ? out0_ready : out1_ready;
  endfunction

  function automatic int m_dest();
    return (m_lock < 0) ? int'(sel) : m_lock;
  endfunction

  function automatic logic m_rdy();
    return rst_n && (!mv[m_dest()] || rdy_in(m_dest()));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        mv[c] = 1'b0; md[c] = 8'h00; ml[c] = 1'b0; mc[c] = 8'h00;
      end
      m_lock = -1;
      m_on   = 1;
    end else if (m_on) begin
      m_d   = m_dest();
      m_acc = s_valid && m_rdy();
      for (int c = 0; c < 2; c++)
        if (mv[c] && rdy_in(c)) mv[c] = 1'b0;
      if (m_acc) begin
        mv[m_d] = 1'b1;
        md[m_d] = s_data;
        ml[m_d] = s_last;
        if (s_last) begin
          mc[m_d] = mc[m_d] + 8'd1;
          m_lock  = -1;
        end else begin
          m_lock = m_d;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("s_ready",    s_ready,    m_rdy());
      chk("out0_valid", out0_valid, mv[0]);
      chk("out0_data",  out0_data,  md[0]);
      chk("out0_last",  out0_last,  ml[0]);
      chk("out1_valid", out1_valid, mv[1]);
      chk("out1_data",  out1_data,  md[1]);
      chk("out1_last",  out1_last,  ml[1]);
      chk("pkt_cnt0",   pkt_cnt0,   mc[0]);
      chk("pkt_cnt1",   pkt_cnt1,   mc[1]);
    end
  end

  task automatic beat(input logic s, input logic [7:0] d, input logic l);
    bit done = 0;
    sel = s; s_data = d; s_last = l; s_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    chk("beat_accept", done, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_v0", out0_valid, 1'b0);
    chk("rst_d1", out1_data, 8'h00);
    chk("rst_cnt1", pkt_cnt1, 8'h00);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back 3-beat packet to out0
    beat(1'b0, 8'h11, 1'b0);
    chk("b2b_first", out0_data, 8'h11);
    chk("b2b_first_v", out0_valid, 1'b1);
    beat(1'b0, 8'h22, 1'b0);
    chk("b2b_second", out0_data, 8'h22);
    beat(1'b0, 8'h33, 1'b1);
    chk("b2b_third", out0_data, 8'h33);
    chk("b2b_last", out0_last, 1'b1);
    chk("b2b_cnt0", pkt_cnt0, 8'd1);
    chk("b2b_out1_quiet", out1_valid, 1'b0);
    idle(2);
    chk("b2b_drained", out0_valid, 1'b0);

    // Select toggles mid-packet; route stays on out0
    beat(1'b0, 8'h40, 1'b0);
    beat(1'b1, 8'h41, 1'b0);
    chk("lock_d", out0_data, 8'h41);
    chk("lock_out1_quiet", out1_valid, 1'b0);
    beat(1'b1, 8'h42, 1'b1);
    chk("lock_tail", out0_data, 8'h42);
    chk("lock_cnt0", pkt_cnt0, 8'd2);
    chk("lock_cnt1", pkt_cnt1, 8'd0);
    beat(1'b1, 8'h50, 1'b1);
    chk("next_pkt_out1", out1_data, 8'h50);
    chk("next_pkt_cnt1", pkt_cnt1, 8'd1);
    idle(2);

    // Backpressure on out1
    out1_ready = 1'b0;
    beat(1'b1, 8'hA5, 1'b1);
    chk("bp_load", out1_data, 8'hA5);
    sel = 1'b1; s_data = 8'h5A; s_last = 1'b1; s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_sready", s_ready, 1'b0);
    chk("bp_hold", out1_data, 8'hA5);
    chk("bp_hold_v", out1_valid, 1'b1);
    out1_ready = 1'b1;
    @(negedge clk);
    chk("bp_sready_open", s_ready, 1'b1);
    @(posedge clk);
    #1;
    out1_ready = 1'b0;
    s_valid = 1'b0;
    chk("bp_reload", out1_data, 8'h5A);
    chk("bp_reload_v", out1_valid, 1'b1);
    idle(2);
    chk("bp_reload_hold", out1_data, 8'h5A);
    out1_ready = 1'b1;
    idle(2);
    chk("bp_drained", out1_valid, 1'b0);

    // out0 stalled while a packet flows to out1
    out0_ready = 1'b0;
    beat(1'b0, 8'h77, 1'b1);
    beat(1'b1, 8'h81, 1'b0);
    beat(1'b1, 8'h82, 1'b1);
    chk("ind_out0_hold", out0_data, 8'h77);
    chk("ind_out0_v", out0_valid, 1'b1);
    chk("ind_out1", out1_data, 8'h82);
    out0_ready = 1'b1;
    idle(2);
    chk("ind_out0_drained", out0_valid, 1'b0);

    // Counter wrap on out1 from a fresh reset
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 255; i++) beat(1'b1, 8'(i), 1'b1);
    chk("wrap_255", pkt_cnt1, 8'd255);
    beat(1'b1, 8'hEE, 1'b1);
    chk("wrap_0", pkt_cnt1, 8'd0);
    chk("wrap_cnt0", pkt_cnt0, 8'd0);
    idle(2);

    // Reset in the middle of a ROUTE1 packet
    beat(1'b1, 8'h91, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_v1", out1_valid, 1'b0);
    chk("mid_rst_d1", out1_data, 8'h00);
    chk("mid_rst_cnt1", pkt_cnt1, 8'd0);
    chk("mid_rst_sready", s_ready, 1'b0);
    rst_n = 1'b1;
    beat(1'b0, 8'h99, 1'b1);
    chk("mid_rst_out0", out0_data, 8'h99);
    chk("mid_rst_out0_v", out0_valid, 1'b1);
    chk("mid_rst_out1_quiet", out1_valid, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
